// File: rtl/cd_cfg_master.sv
// Configuration bus initiator for the clock divider.
// Collects a byte-framed command from the UART RX stream (sync, addr, data MSB-first, checksum),
// validates the XOR checksum and issues a single c_valid/c_ready write, aborting on timeout.
module cd_cfg_master #(
    parameter int unsigned WIDTH_CONFIG_ADDR = 8,
    parameter int unsigned WIDTH_CONFIG_DATA = 16,
    parameter int unsigned DATA_BYTES        = 2,
    parameter logic [7:0]  SYNC_BYTE         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES    = 1024,
    parameter int unsigned WIDTH_TIMEOUT     = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    output logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_valid,
    input  logic                         c_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err_csum,
    output logic                         err_timeout
);

    localparam int unsigned ShiftW = DATA_BYTES * 8;
    localparam int unsigned CntW   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [CntW-1:0]          LastByte    = CntW'(DATA_BYTES - 1);
    localparam logic [WIDTH_TIMEOUT-1:0] TimeoutLast = WIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StCsum  = 3'd3;
    localparam logic [2:0] StIssue = 3'd4;

    logic [2:0]                   state_q, state_d;
    logic [WIDTH_CONFIG_ADDR-1:0] addr_q, addr_d;
    logic [ShiftW-1:0]            data_q, data_d;
    logic [7:0]                   csum_q, csum_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [WIDTH_TIMEOUT-1:0]     tmo_q, tmo_d;
    logic                         done_q, done_d;
    logic                         err_csum_q, err_csum_d;
    logic                         err_timeout_q, err_timeout_d;
    logic                         accept;

    assign accept = rx_valid & rx_ready;

    // Frame parser and write-issue next-state logic.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        csum_d        = csum_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        done_d        = 1'b0;
        err_csum_d    = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (accept) begin
                    addr_d  = rx_data[WIDTH_CONFIG_ADDR-1:0];
                    csum_d  = rx_data;
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (accept) begin
                    // Shift/OR form stays legal when DATA_BYTES is 1.
                    data_d = (data_q << 8) | ShiftW'(rx_data);
                    csum_d = csum_q ^ rx_data;
                    if (cnt_q == LastByte) begin
                        state_d = StCsum;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        tmo_d   = '0;
                        state_d = StIssue;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StIssue: begin
                // A handshake on the final allowed cycle takes priority over the abort.
                if (c_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (tmo_q == TimeoutLast) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            data_q        <= '0;
            csum_q        <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            done_q        <= 1'b0;
            err_csum_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            csum_q        <= csum_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            done_q        <= done_d;
            err_csum_q    <= err_csum_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign rx_ready    = (state_q != StIssue);
    assign c_valid     = (state_q == StIssue);
    assign busy        = (state_q != StIdle);
    assign c_addr      = addr_q;
    assign c_data      = data_q[WIDTH_CONFIG_DATA-1:0];
    assign done        = done_q;
    assign err_csum    = err_csum_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_cd_cfg_master.sv
// Scoreboard bench for cd_cfg_master: one default instance and one with an 8-cycle timeout.
module tb_cd_cfg_master;

    localparam logic [2:0] KindDone = 3'b100;
    localparam logic [2:0] KindCsum = 3'b010;
    localparam logic [2:0] KindTo   = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
        int          vw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        c_ready = 1'b0;
    logic        sel;

    logic        rx_ready_m, c_valid_m, busy_m, done_m, err_csum_m, err_to_m;
    logic [7:0]  c_addr_m;
    logic [15:0] c_data_m;
    logic        rx_ready_t, c_valid_t, busy_t, done_t, err_csum_t, err_to_t;
    logic [7:0]  c_addr_t;
    logic [15:0] c_data_t;

    logic        m_rx_ready, m_c_valid, m_busy, m_done, m_err_csum, m_err_to;
    logic [7:0]  m_addr;
    logic [15:0] m_data;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   stall    = 0;
    int   icnt     = 0;
    int   vw       = 0;
    logic [7:0]  a0;
    logic [15:0] d0;

    always #5 clk = ~clk;

    cd_cfg_master u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid & ~sel),
        .rx_ready    (rx_ready_m),
        .c_addr      (c_addr_m),
        .c_data      (c_data_m),
        .c_valid     (c_valid_m),
        .c_ready     (c_ready & ~sel),
        .busy        (busy_m),
        .done        (done_m),
        .err_csum    (err_csum_m),
        .err_timeout (err_to_m)
    );

    cd_cfg_master #(
        .TIMEOUT_CYCLES (8),
        .WIDTH_TIMEOUT  (3)
    ) u_dut_to (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid & sel),
        .rx_ready    (rx_ready_t),
        .c_addr      (c_addr_t),
        .c_data      (c_data_t),
        .c_valid     (c_valid_t),
        .c_ready     (c_ready & sel),
        .busy        (busy_t),
        .done        (done_t),
        .err_csum    (err_csum_t),
        .err_timeout (err_to_t)
    );

    assign m_rx_ready = sel ? rx_ready_t : rx_ready_m;
    assign m_c_valid  = sel ? c_valid_t  : c_valid_m;
    assign m_busy     = sel ? busy_t     : busy_m;
    assign m_done     = sel ? done_t     : done_m;
    assign m_err_csum = sel ? err_csum_t : err_csum_m;
    assign m_err_to   = sel ? err_to_t   : err_to_m;
    assign m_addr     = sel ? c_addr_t   : c_addr_m;
    assign m_data     = sel ? c_data_t   : c_data_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Responder: hold c_ready low for 'stall' ISSUE cycles, then raise it.
    always @(negedge clk) begin
        if (m_c_valid) begin
            c_ready = (icnt >= stall);
            icnt++;
        end else begin
            icnt    = 0;
            c_ready = (stall == 0);
        end
    end

    // Monitor: measure c_valid width, check stability, pop scoreboard on each pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m_c_valid) begin
                if (vw == 0) begin
                    a0 = m_addr;
                    d0 = m_data;
                end else begin
                    check("addr_stable", {24'd0, m_addr}, {24'd0, a0});
                    check("data_stable", {16'd0, m_data}, {16'd0, d0});
                end
                check("rx_ready_in_issue", {31'd0, m_rx_ready}, 32'd0);
                vw++;
            end
            if (m_done || m_err_csum || m_err_to) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", {29'd0, m_done, m_err_csum, m_err_to}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {29'd0, m_done, m_err_csum, m_err_to}, {29'd0, e.kind});
                    check("valid_width", vw, e.vw);
                    check("valid_dropped", {31'd0, m_c_valid}, 32'd0);
                    if (e.kind == KindDone) begin
                        check("c_addr", {24'd0, a0}, {24'd0, e.addr});
                        check("c_data", {16'd0, d0}, {16'd0, e.data});
                    end
                end
                vw = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_c_valid"},  {31'd0, m_c_valid},  32'd0);
        check({tag, "_c_addr"},   {24'd0, m_addr},     32'd0);
        check({tag, "_c_data"},   {16'd0, m_data},     32'd0);
        check({tag, "_busy"},     {31'd0, m_busy},     32'd0);
        check({tag, "_rx_ready"}, {31'd0, m_rx_ready}, 32'd1);
        check({tag, "_pulses"},   {29'd0, m_done, m_err_csum, m_err_to}, 32'd0);
    endtask

    // Model: derive the expected outcome from the frame bytes, then drive the frame.
    task automatic run_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] cs,
                             input int st);
        exp_t e;
        int   tmo;
        stall = st;
        tmo   = sel ? 8 : 1024;
        if (cs != (a ^ d[15:8] ^ d[7:0])) begin
            e = '{kind: KindCsum, addr: 8'd0, data: 16'd0, vw: 0};
        end else if (st >= tmo) begin
            e = '{kind: KindTo, addr: 8'd0, data: 16'd0, vw: tmo};
        end else begin
            e = '{kind: KindDone, addr: a, data: d, vw: st + 1};
        end
        exp_q.push_back(e);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        send_byte(cs);
        wait_drain(2000);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel      = 1'b0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        run_frame(8'h01, 16'h1234, 8'h27, 0);    // good frame, c_ready held high
        run_frame(8'h01, 16'h1234, 8'h27, 20);   // stalled responder
        run_frame(8'h01, 16'h1234, 8'h26, 0);    // bad checksum
        run_frame(8'h02, 16'h0005, 8'h07, 0);    // recovery frame

        sel = 1'b1;
        run_frame(8'h01, 16'h1234, 8'h27, 1000); // c_ready stuck low: timeout
        run_frame(8'h01, 16'h1234, 8'h27, 7);    // c_ready on final cycle: handshake wins

        sel   = 1'b0;
        stall = 0;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        @(negedge clk);
        check("busy_mid_frame", {31'd0, m_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midframe_reset");
        run_frame(8'h03, 16'h0001, 8'h02, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cd_cfg_master.md
Name: cd_cfg_master

Overview:
- Initiator side of the clock-divider configuration bus (c_addr/c_data/c_valid/c_ready).
- Receives a byte-framed configuration command from the UART receive path, validates it, and issues one bus write. Holds the write until the clock divider returns c_ready, or aborts on timeout.
- Sits between the UART RX byte stream and the clock divider configuration port.
- Runs in the same clock domain as the config responder.

Parameters:
- WIDTH_CONFIG_ADDR, 8, config address width (1..8).
- WIDTH_CONFIG_DATA, 16, config data width (1..32).
- DATA_BYTES, 2, bytes per data field; must equal ceil(WIDTH_CONFIG_DATA/8).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, maximum ISSUE cycles without c_ready.
- WIDTH_TIMEOUT, 10, counter width; 2^WIDTH_TIMEOUT >= TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts byte; a byte transfers on rx_valid & rx_ready at the clock edge.
- c_addr  out  WIDTH_CONFIG_ADDR  config address.
- c_data  out  WIDTH_CONFIG_DATA  config data.
- c_valid  out  1  write request.
- c_ready  in  1  responder ready/acknowledge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on a completed write.
- err_csum  out  1  one-cycle pulse on checksum mismatch.
- err_timeout  out  1  one-cycle pulse on write abort.

Behaviour:
- Frame format: SYNC_BYTE, ADDR, DATA[MSB byte first] x DATA_BYTES, CSUM.
- CSUM = XOR of ADDR and all DATA bytes; SYNC_BYTE is excluded.
- FSM states: IDLE, ADDR, DATA, CSUM, ISSUE. All transitions occur on accepted bytes or at the clock edge.
- IDLE:
  - rx_ready=1.
  - Accepted byte == SYNC_BYTE goes to ADDR.
  - Any other byte is dropped silently.
- ADDR:
  - Accepted byte: the low WIDTH_CONFIG_ADDR bits are stored in the address register.
  - The running checksum is initialised to that byte.
  - Next state is DATA; the byte counter is cleared.
- DATA:
  - Each accepted byte shifts the data shift register left 8 and ORs in the byte.
  - The byte is XORed into the running checksum.
  - After DATA_BYTES bytes, go to CSUM.
  - c_data takes the low WIDTH_CONFIG_DATA bits of the shift register.
- CSUM:
  - Accepted byte == running checksum: go to ISSUE; the timeout counter is cleared.
  - Mismatch: err_csum pulses on the following cycle, go to IDLE, no bus write.
- ISSUE:
  - rx_ready=0 and c_valid=1.
  - c_addr/c_data stay stable for the whole of ISSUE.
  - c_ready sampled high at an edge: that is the handshake. On the next cycle c_valid=0, done=1 for one cycle, state IDLE.
  - c_ready already high on entry: the handshake completes in the first ISSUE cycle, giving minimum c_valid width 1.
  - Timeout counter increments each ISSUE cycle without c_ready.
  - Counter == TIMEOUT_CYCLES-1 with c_ready low at that edge: abort. Next cycle c_valid=0, err_timeout=1 for one cycle, state IDLE.
  - c_ready high on that same final cycle: the handshake wins. done pulses and err_timeout stays 0.
- rx_ready=1 in IDLE, ADDR, DATA and CSUM. rx_valid is ignored while in ISSUE.
- A SYNC_BYTE value arriving mid-frame is treated as ordinary data; there is no resync inside a frame.
- c_addr/c_data keep the last issued values after the write, until the next frame overwrites them.
- Reset values: state IDLE; c_valid=0; c_addr=0; c_data=0; done=0; err_csum=0; err_timeout=0; busy=0; rx_ready=1 in the first cycle after rst deasserts.
- Reset mid-frame or mid-ISSUE: the frame is discarded and c_valid drops on the cycle after rst is sampled. No done or err pulse is produced.
- Latency:
  - c_valid rises 1 cycle after the edge that accepts the CSUM byte.
  - done rises 1 cycle after the c_ready handshake edge.

Test Plan:
- Good frame: bytes A5,01,12,34,27 back-to-back with c_ready held 1. Required: c_valid=1 for exactly 1 cycle with c_addr=0x01 and c_data=0x1234, then done pulses once. No err pulse.
- Stalled responder: same frame with c_ready=0 for 20 cycles, then 1. Required: c_valid held 21 cycles with c_addr/c_data stable; rx_ready=0 throughout ISSUE; done pulses once.
- Bad checksum: A5,01,12,34,26. Required: err_csum pulses once and c_valid is never asserted. A following good frame A5,02,00,05,07 issues c_addr=0x02 and c_data=0x0005.
- Timeout: TIMEOUT_CYCLES=8, good frame, c_ready stuck 0. Required: c_valid high exactly 8 cycles, then err_timeout pulses once, no done.
- Timeout boundary: TIMEOUT_CYCLES=8, c_ready raised on the 8th ISSUE cycle. Required: done=1 and err_timeout=0.
- Garbage and reset: bytes 00,FF,A5 then rst asserted for 1 cycle, then A5,03,00,01,02. Required: the first frame is discarded, all outputs are at reset values after rst, and the write issues c_addr=0x03 and c_data=0x0001.
